// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, default geometry
// and the inter-frame gap length helper.
package spi_master_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // Final value of the GAP counter; counting 0..clk_div+1 keeps ss high for
  // clk_div+2 cycles so a slave that synchronises its inputs can reload.
  function automatic int gap_last(input int clk_div);
    return clk_div + 1;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Down-counter that issues a one-cycle tick every CLK_DIV clk cycles.
// Held at its reload value while load is high so the first tick lands CLK_DIV cycles later.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg - CW'(1);
    if (load || (cnt_reg == '0)) begin
      cnt_next = RELOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= RELOAD;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = (cnt_reg == '0) && !load;

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (sck idle low, sample on rising edge), MSB first.
// One word per start pulse; every output comes straight from a register.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  ss,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam int GCW = $clog2(CLK_DIV + 2);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(gap_last(CLK_DIV));

  state_t state_reg, state_next;

  logic                  ss_reg,   ss_next;
  logic                  sck_reg,  sck_next;
  logic                  mosi_reg, mosi_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic [DATA_WIDTH-1:0] tx_reg,   tx_next;
  logic [DATA_WIDTH-1:0] rx_reg,   rx_next;
  logic [BCW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [GCW-1:0]        gap_cnt_reg, gap_cnt_next;

  logic                  tick;
  logic                  tick_load;
  logic                  last_bit;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  gap_done;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;

  // The divider is parked while idle, so SETUP always lasts a full half-period.
  assign tick_load = (state_reg == S_IDLE);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .load (tick_load),
    .tick (tick)
  );

  assign last_bit = (bit_cnt_reg == LAST_BIT);
  assign gap_done = (gap_cnt_reg == GAP_LAST);

  // After the last falling edge XFER waits one more low half-period before HOLD.
  assign sck_rise = tick && ((state_reg == S_SETUP) ||
                             ((state_reg == S_XFER) && !sck_reg && !last_bit));
  assign sck_fall = tick && (state_reg == S_XFER) && sck_reg;

  assign tx_shift = tx_reg << 1;

  assign rx_shift[0] = miso;
  for (genvar gi = 1; gi < DATA_WIDTH; gi++) begin : g_rx_shift
    assign rx_shift[gi] = rx_reg[gi-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      ss_reg      <= 1'b1;
      sck_reg     <= 1'b0;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dout_reg    <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ss_reg      <= ss_next;
      sck_reg     <= sck_next;
      mosi_reg    <= mosi_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      dout_reg    <= dout_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start)                        state_next = S_SETUP;
      S_SETUP: if (tick)                         state_next = S_XFER;
      S_XFER:  if (tick && !sck_reg && last_bit) state_next = S_HOLD;
      S_HOLD:  if (tick)                         state_next = S_GAP;
      S_GAP:   if (gap_done)                     state_next = S_IDLE;
      default:                                   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ss_next      = ss_reg;
    sck_next     = sck_reg;
    mosi_next    = mosi_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    dout_next    = dout_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          tx_next      = din;
          bit_cnt_next = '0;
          ss_next      = 1'b0;
          busy_next    = 1'b1;
          sck_next     = 1'b0;
          mosi_next    = din[DATA_WIDTH-1];
        end
      end
      S_SETUP, S_XFER: begin
        if (sck_rise) begin
          sck_next     = 1'b1;
          rx_next      = rx_shift;
          bit_cnt_next = bit_cnt_reg + BCW'(1);
        end else if (sck_fall) begin
          sck_next = 1'b0;
          // No shift on the final falling edge: the last bit stays on mosi.
          if (!last_bit) begin
            tx_next   = tx_shift;
            mosi_next = tx_shift[DATA_WIDTH-1];
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          ss_next      = 1'b1;
          dout_next    = rx_reg;
          done_next    = 1'b1;
          gap_cnt_next = '0;
        end
      end
      S_GAP: begin
        busy_next = 1'b0;
        if (!gap_done) begin
          gap_cnt_next = gap_cnt_reg + GCW'(1);
        end
      end
      default: begin
        ss_next  = 1'b1;
        sck_next = 1'b0;
      end
    endcase
  end

  assign ss   = ss_reg;
  assign sck  = sck_reg;
  assign mosi = mosi_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign dout = dout_reg;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: random words exchanged with a behavioural
// slave (or looped back), plus timing, reset-abort and CLK_DIV=1 scenarios.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int DW   = 16;
  localparam int DIV  = 4;
  localparam int DIV1 = 1;

  typedef struct {
    logic [DW-1:0] m_exp;
    logic [DW-1:0] s_exp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, start1;
  logic [DW-1:0] din, din1, dout, dout1;
  logic          busy, done, ss, sck, mosi, miso;
  logic          busy1, done1, ss1, sck1, mosi1;
  logic          loopback;
  logic [DW-1:0] slv_word;
  logic [DW-1:0] slv_tx = '0;
  logic [DW-1:0] slv_rx = '0;
  logic          slv_ss_q = 1'b1;
  logic          slv_sck_q = 1'b0;
  logic          slv_miso;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  assign slv_miso = slv_tx[DW-1];
  assign miso     = loopback ? mosi : slv_miso;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) u_dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .dout(dout), .busy(busy),
    .done(done), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .dout(dout1), .busy(busy1),
    .done(done1), .ss(ss1), .sck(sck1), .mosi(mosi1), .miso(1'b1)
  );

  // Mode-0 slave: loads its word when selected, captures mosi on sck rise, shifts on fall.
  always @(negedge clk) begin
    if (slv_ss_q && !ss) begin
      slv_tx <= slv_word;
      slv_rx <= '0;
    end else if (!ss && !slv_sck_q && sck) begin
      slv_rx <= {slv_rx[DW-2:0], mosi};
    end else if (!ss && slv_sck_q && !sck) begin
      slv_tx <= slv_tx << 1;
    end
    slv_ss_q  <= ss;
    slv_sck_q <= sck;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic check_min(input string name, input int got, input int least);
    n_cmp++;
    if (got < least) begin
      n_err++;
      $display("FAIL %s: got %0d want >= %0d", name, got, least);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic run_monitor();
    exp_t e;
    int   ss_low_len = 0;
    int   ss_high_len = 0;
    int   sck_rises = 0;
    logic prev_ss = 1'b1;
    logic prev_sck = 1'b0;
    logic prev_done = 1'b0;
    logic gap_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ss_low_len = 0; ss_high_len = 0; sck_rises = 0;
        prev_ss = 1'b1; prev_sck = 1'b0; prev_done = 1'b0; gap_valid = 1'b0;
        continue;
      end
      if (prev_done) begin
        check("done_width", 32'(done), 32'(0));
        check("busy_after_done", 32'(busy), 32'(0));
      end
      if (!ss && prev_ss) begin
        if (gap_valid) check_min("ss_gap", ss_high_len, DIV + 2);
        ss_low_len = 0; ss_high_len = 0; sck_rises = 0;
      end
      if (!ss) ss_low_len++;
      else     ss_high_len++;
      if (sck && !prev_sck) sck_rises++;
      if (done) begin
        done_cnt++;
        check("busy_at_done", 32'(busy), 32'(1));
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e.m_exp));
          check("slave_rx", 32'(slv_rx), 32'(e.s_exp));
          check("ss_low_len", ss_low_len, 2 * DW * DIV + 2 * DIV);
          check("sck_rises", sck_rises, DW);
        end
        gap_valid = 1'b1;
      end
      prev_ss = ss; prev_sck = sck; prev_done = done;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("xfer_end", 32'(busy), 32'(0));
    repeat (DIV + 4) @(negedge clk);
  endtask

  task automatic xfer(input logic [DW-1:0] m, input logic [DW-1:0] s, input logic lb,
                      input logic poke);
    exp_t e;
    int   d0;
    int   n = 0;
    @(negedge clk);
    loopback = lb; slv_word = s; din = m; start = 1'b1;
    e.m_exp = lb ? m : s;
    e.s_exp = m;
    exp_q.push_back(e);
    d0 = done_cnt;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(busy), 32'(1));
    start = 1'b0;
    din = DW'($urandom);
    if (poke) begin
      repeat (3 * DIV + 20) @(negedge clk);
      start = 1'b1; din = '1;
      repeat (4) @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   d0, n, r, last, low;
    logic ps;
    rst = 1'b1; start = 1'b0; din = '0; start1 = 1'b0; din1 = '0;
    loopback = 1'b1; slv_word = '0;
    fork
      run_monitor();
    join_none
    repeat (4) @(negedge clk);
    check("rst_ss", 32'(ss), 32'(1));
    check("rst_sck", 32'(sck), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_ss1", 32'(ss1), 32'(1));
    check("rst_mosi1", 32'(mosi1), 32'(0));
    rst = 1'b0;

    xfer(16'hA5C3, 16'h0000, 1'b1, 1'b0);
    xfer(16'hBEEF, 16'h1234, 1'b0, 1'b0);
    xfer(16'h3C5A, 16'h9F01, 1'b0, 1'b1);
    xfer(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    xfer(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      xfer(DW'($urandom), DW'($urandom), 1'(i % 2), 1'b0);
    end

    // start held high: three back-to-back frames
    @(negedge clk);
    loopback = 1'b0; slv_word = 16'h6B2D; din = 16'hC0DE; start = 1'b1;
    e.m_exp = 16'h6B2D; e.s_exp = 16'hC0DE;
    repeat (3) exp_q.push_back(e);
    d0 = done_cnt; n = 0;
    while ((done_cnt - d0) < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_idle();
    check("cont_done_count", done_cnt - d0, 3);

    // reset and start in the same cycle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; din = 16'h1357;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'(0));
    check("rst_prio_ss", 32'(ss), 32'(1));

    // abort after five sck rises
    @(negedge clk);
    loopback = 1'b1; din = 16'h5AA5; start = 1'b1;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    d0 = done_cnt; r = 0; n = 0; ps = 1'b0;
    while (r < 5 && n < 500) begin
      @(negedge clk);
      n++;
      if (sck && !ps) r++;
      ps = sck;
    end
    check("abort_rises", r, 5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss", 32'(ss), 32'(1));
    check("abort_sck", 32'(sck), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_dout", 32'(dout), 32'(0));
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_dout_later", 32'(dout), 32'(0));

    // CLK_DIV=1 instance, miso tied high
    @(negedge clk);
    din1 = DW'($urandom); start1 = 1'b1;
    n = 0; r = 0; last = -1; low = 0; ps = 1'b0;
    while (!done1 && n < 300) begin
      @(negedge clk);
      n++;
      if (busy1) start1 = 1'b0;
      if (!ss1) low++;
      if (sck1 && !ps) begin
        if (last >= 0) check("sck_period1", n - last, 2);
        last = n;
        r++;
      end
      ps = sck1;
    end
    start1 = 1'b0;
    check("done1_seen", 32'(done1), 32'(1));
    check("dout1", 32'(dout1), 32'(16'hFFFF));
    check("rises1", r, DW);
    check("ss_low1", low, 2 * DW * DIV1 + 2 * DIV1);
    @(negedge clk);
    check("done1_width", 32'(done1), 32'(0));
    check("busy1_after", 32'(busy1), 32'(0));

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word length in bits, shifted MSB first.
REQ-002 Parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 1..255.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  transfer request, sampled only in IDLE.
REQ-006 Port din  input  DATA_WIDTH  word to transmit, latched on accepted start.
REQ-007 Port dout  output  DATA_WIDTH  last received word, valid from the done pulse until the next done pulse.
REQ-008 Port busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.
REQ-009 Port done  output  1  one-cycle pulse when the transfer completes.
REQ-010 Port ss  output  1  slave select, active-low.
REQ-011 Port sck  output  1  serial clock, idle low (CPOL=0, CPHA=0).
REQ-012 Port mosi  output  1  serial data out.
REQ-013 Port miso  input  1  serial data in.

Function
REQ-014 FSM states: IDLE, SETUP, XFER, HOLD, GAP; all outputs registered.
REQ-015 IDLE with start=1: latch din into tx shift register, clear bit counter, go to SETUP; next cycle ss=0, busy=1, mosi=din[MSB].
REQ-016 SETUP: sck low for CLK_DIV cycles, then XFER.
REQ-017 XFER: sck toggles every CLK_DIV cycles, giving exactly DATA_WIDTH rising and DATA_WIDTH falling edges, first edge rising.
REQ-018 On the clk cycle sck is driven high, sample miso into the LSB of the rx shift register and increment the bit counter.
REQ-019 On each falling edge except the last, shift tx left and drive the new MSB on mosi; mosi stays stable across each rising edge.
REQ-020 After the DATA_WIDTH-th falling edge: HOLD for CLK_DIV cycles, sck low, ss low.
REQ-021 HOLD exit: ss=1, dout=rx register, done=1 for one cycle, busy=0 in the following cycle, enter GAP.
REQ-022 GAP: ss high for at least CLK_DIV+2 cycles (lets a sync-input slave reload), start ignored, then IDLE.
REQ-023 start while not IDLE is ignored; no queuing.
REQ-024 Bit counter width clog2(DATA_WIDTH+1); no wrap within a transfer.
REQ-025 din changes after acceptance have no effect on the current transfer.
REQ-026 CLK_DIV=1: sck period 2 clk cycles; all rules above still hold.

Reset
REQ-027 On rst: state=IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, dout=0, counters cleared.
REQ-028 rst mid-transfer aborts it: ss=1 and sck=0 on the next cycle, no done pulse, dout unchanged from reset value 0.
REQ-029 rst has priority over start in the same cycle.

Structure
REQ-030 Shared package holds the FSM state encoding and the default DATA_WIDTH and CLK_DIV constants.
REQ-031 One sub-module, spi_tick_gen: CLK_DIV down-counter issuing a one-cycle tick, reloaded whenever the FSM leaves IDLE.

Verification
REQ-032 Loopback mosi->miso, din=0xA5C3, start pulse -> ss low 2*16*4+2*4 cycles, 16 sck rises, done once, dout=0xA5C3.
REQ-033 Against the team's spi_slave, slave din=0x1234 and master din=0xBEEF -> master dout=0x1234, slave dout=0xBEEF, slave done once.
REQ-034 start held high continuously -> transfers separated by ss high of at least CLK_DIV+2 cycles, each done pulse one cycle wide.
REQ-035 start during XFER with din=0xFFFF -> ignored; current word unaffected, exactly one done.
REQ-036 rst asserted after 5 sck rises -> next cycle ss=1, sck=0, busy=0, no done, dout=0.
REQ-037 CLK_DIV=1, miso tied 1 -> sck period 2 cycles, dout=0xFFFF.
